// File: rtl/wdt_pkg.sv
// Shared types, default widths and helpers for the multi-channel watchdog.
package wdt_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_PRE_W  = 8;
  localparam int MAX_CNT_W  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    WARN    = 2'd2,
    TIMEOUT = 2'd3
  } wdt_state_e;

  // A warning threshold is only meaningful if it is nonzero and lands before the timeout.
  function automatic logic warn_valid(input logic [MAX_CNT_W-1:0] warncnt,
                                      input logic [MAX_CNT_W-1:0] tocnt);
    return (warncnt != '0) && (warncnt < tocnt);
  endfunction

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: config/lock registers, state machine, counter and registered outputs.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr,
  input  logic             cfg_en,
  input  logic             cfg_lock,
  input  logic [CNT_W-1:0] cfg_tocnt,
  input  logic [CNT_W-1:0] cfg_warncnt,
  input  logic [CNT_W-1:0] cfg_winmin,
  input  logic             kick,
  output logic             active,
  output logic             wto,
  output logic             warn,
  output logic             early,
  output logic [CNT_W-1:0] cnt
);

  wdt_state_e       state;
  logic             lock;
  logic [CNT_W-1:0] tocnt, warncnt, winmin;

  logic             wr_ok;
  logic [CNT_W-1:0] to_eff, warn_eff, win_eff, cnt_inc;
  logic             warn_ok;

  // A same-cycle write is already in force for that cycle's kick/tick evaluation.
  assign wr_ok    = wr && !lock;
  assign to_eff   = wr_ok ? cfg_tocnt   : tocnt;
  assign warn_eff = wr_ok ? cfg_warncnt : warncnt;
  assign win_eff  = wr_ok ? cfg_winmin  : winmin;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign warn_ok  = warn_valid(MAX_CNT_W'(warn_eff), MAX_CNT_W'(to_eff));
  assign active   = (state != IDLE);

  // NOTE: all sequential state is assigned with non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tocnt   <= '0;
      warncnt <= '0;
      winmin  <= '0;
      lock    <= 1'b0;
      wto     <= 1'b0;
      warn    <= 1'b0;
      early   <= 1'b0;
    end else begin
      if (wr_ok) begin
        tocnt   <= cfg_tocnt;
        warncnt <= cfg_warncnt;
        winmin  <= cfg_winmin;
        if (cfg_lock) lock <= 1'b1;
      end

      if (wr_ok && !cfg_en) begin
        state <= IDLE;
        cnt   <= '0;
        wto   <= 1'b0;
        warn  <= 1'b0;
        early <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (wr_ok) begin
              state <= COUNT;
              cnt   <= '0;
            end
          end
          COUNT, WARN: begin
            if (kick) begin
              if ((win_eff != '0) && (cnt < win_eff)) begin
                state <= TIMEOUT;
                wto   <= 1'b1;
                early <= 1'b1;
              end else begin
                state <= COUNT;
                cnt   <= '0;
                warn  <= 1'b0;
              end
            end else if (tick) begin
              if (cnt == to_eff) begin
                state <= TIMEOUT;
                wto   <= 1'b1;
              end else begin
                cnt <= cnt_inc;
                if (warn_ok && (cnt_inc == warn_eff)) begin
                  state <= WARN;
                  warn  <= 1'b1;
                end
              end
            end
          end
          TIMEOUT: begin
            // Latched until a disable write or reset.
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog top: shared prescaler, write decode, count readback and timeout summary.
module wdt_multi
  import wdt_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  parameter  int PRE_W  = DEF_PRE_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PRE_W-1:0]  presc,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_sel,
  input  logic              cfg_en,
  input  logic              cfg_lock,
  input  logic [CNT_W-1:0]  cfg_tocnt,
  input  logic [CNT_W-1:0]  cfg_warncnt,
  input  logic [CNT_W-1:0]  cfg_winmin,
  input  logic [NUM_CH-1:0] kick,
  output logic [NUM_CH-1:0] wto,
  output logic [NUM_CH-1:0] warn,
  output logic [NUM_CH-1:0] early,
  output logic              wto_any,
  output logic [CNT_W-1:0]  rd_cnt
);

  logic [PRE_W-1:0]  pcnt;
  logic              running, tick;
  logic [NUM_CH-1:0] active, we_dec;
  logic [CNT_W-1:0]  cnt_arr [NUM_CH];

  // The prescaler idles at zero so the first tick is a full period after any channel starts.
  assign running = |active;
  assign tick    = running && (pcnt == presc);

  always_ff @(posedge clk) begin
    if (rst || !running) pcnt <= '0;
    else if (pcnt == presc) pcnt <= '0;
    else pcnt <= pcnt + PRE_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign we_dec[i] = cfg_we && (cfg_sel == CH_W'(i));

    wdt_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .wr          (we_dec[i]),
      .cfg_en      (cfg_en),
      .cfg_lock    (cfg_lock),
      .cfg_tocnt   (cfg_tocnt),
      .cfg_warncnt (cfg_warncnt),
      .cfg_winmin  (cfg_winmin),
      .kick        (kick[i]),
      .active      (active[i]),
      .wto         (wto[i]),
      .warn        (warn[i]),
      .early       (early[i]),
      .cnt         (cnt_arr[i])
    );
  end

  // NOTE: default assignment first in always_comb so no path leaves rd_cnt unassigned (no latch).
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_sel == CH_W'(i)) rd_cnt = cnt_arr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wto_any <= 1'b0;
    else     wto_any <= |wto;
  end

endmodule

// File: tb/tb_wdt_multi.sv
// Self-checking bench for wdt_multi: directed scenarios plus randomized traffic against a flag-based model.
module tb_wdt_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PRE_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [PRE_W-1:0]  presc;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_sel;
  logic              cfg_en, cfg_lock;
  logic [CNT_W-1:0]  cfg_tocnt, cfg_warncnt, cfg_winmin;
  logic [NUM_CH-1:0] kick, wto, warn, early;
  logic              wto_any;
  logic [CNT_W-1:0]  rd_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a channel is "on" from an enable until a disable; "fired" means timed out.
  logic [NUM_CH-1:0] m_on, m_fired, m_warn, m_early, m_lock;
  logic [CNT_W-1:0]  m_cnt [NUM_CH];
  logic [CNT_W-1:0]  m_to  [NUM_CH];
  logic [CNT_W-1:0]  m_wc  [NUM_CH];
  logic [CNT_W-1:0]  m_win [NUM_CH];
  logic [PRE_W-1:0]  m_pc;
  logic              m_wany;

  wdt_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .presc       (presc),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_en      (cfg_en),
    .cfg_lock    (cfg_lock),
    .cfg_tocnt   (cfg_tocnt),
    .cfg_warncnt (cfg_warncnt),
    .cfg_winmin  (cfg_winmin),
    .kick        (kick),
    .wto         (wto),
    .warn        (warn),
    .early       (early),
    .wto_any     (wto_any),
    .rd_cnt      (rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = '0; m_fired = '0; m_warn = '0; m_early = '0; m_lock = '0;
    m_pc = '0; m_wany = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = '0; m_to[c] = '0; m_wc[c] = '0; m_win[c] = '0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_eval();
    logic any_on, tk, wr;
    if (rst) begin
      model_reset();
      return;
    end
    any_on = |m_on;
    tk     = any_on && (m_pc == presc);
    m_wany = |m_fired;
    for (int c = 0; c < NUM_CH; c++) begin
      wr = cfg_we && (int'(cfg_sel) == c) && !m_lock[c];
      if (wr) begin
        m_to[c] = cfg_tocnt; m_wc[c] = cfg_warncnt; m_win[c] = cfg_winmin;
        if (cfg_lock) m_lock[c] = 1'b1;
      end
      if (wr && !cfg_en) begin
        m_on[c] = 0; m_fired[c] = 0; m_warn[c] = 0; m_early[c] = 0; m_cnt[c] = '0;
      end else if (!m_on[c]) begin
        if (wr) begin m_on[c] = 1; m_cnt[c] = '0; end
      end else if (!m_fired[c]) begin
        if (kick[c]) begin
          if (m_win[c] != 0 && m_cnt[c] < m_win[c]) begin
            m_fired[c] = 1; m_early[c] = 1;
          end else begin
            m_cnt[c] = '0; m_warn[c] = 0;
          end
        end else if (tk) begin
          if (m_cnt[c] == m_to[c]) m_fired[c] = 1;
          else begin
            m_cnt[c] = m_cnt[c] + 32'd1;
            if (m_cnt[c] == m_wc[c] && m_wc[c] != 0 && m_wc[c] < m_to[c]) m_warn[c] = 1;
          end
        end
      end
    end
    if (!any_on || m_pc == presc) m_pc = '0;
    else m_pc = m_pc + 8'd1;
  endtask

  // One clock: update model, clock DUT, sample 1ns after the edge, compare, drop pulses.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("wto",     64'(wto),     64'(m_fired));
    check("warn",    64'(warn),    64'(m_warn));
    check("early",   64'(early),   64'(m_early));
    check("wto_any", 64'(wto_any), 64'(m_wany));
    check("rd_cnt",  64'(rd_cnt),  64'(m_cnt[cfg_sel]));
    cfg_we = 1'b0; kick = '0; rst = 1'b0; cfg_lock = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr_cfg(input int ch, input logic en, input logic lk,
                        input int to, input int wc, input int win);
    cfg_sel = CH_W'(ch); cfg_en = en; cfg_lock = lk;
    cfg_tocnt = CNT_W'(to); cfg_warncnt = CNT_W'(wc); cfg_winmin = CNT_W'(win);
    cfg_we = 1'b1;
    step();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
  endtask

  initial begin
    model_reset();
    presc = '0; cfg_we = 0; cfg_sel = '0; cfg_en = 0; cfg_lock = 0;
    cfg_tocnt = '0; cfg_warncnt = '0; cfg_winmin = '0; kick = '0;
    do_rst();
    check("rst_outs", 64'({wto, warn, early, wto_any}), 64'd0);
    check("rst_cnt",  64'(rd_cnt), 64'd0);

    // Plain timeout with presc=0: wto 10 cycles after COUNT entry, wto_any one later.
    wr_cfg(0, 1, 0, 9, 0, 0);
    run(9);
    check("s1_wto_pre",  64'(wto[0]), 64'd0);
    step();
    check("s1_wto",      64'(wto[0]), 64'd1);
    check("s1_any_lag",  64'(wto_any), 64'd0);
    step();
    check("s1_any",      64'(wto_any), 64'd1);
    check("s1_others",   64'(wto[3:1]), 64'd0);

    // Warning then timeout with presc=3.
    do_rst();
    presc = 8'd3;
    wr_cfg(1, 1, 0, 4, 2, 0);
    run(7);
    check("s2_warn_pre", 64'(warn[1]), 64'd0);
    step();
    check("s2_warn",     64'(warn[1]), 64'd1);
    run(11);
    check("s2_wto_pre",  64'(wto[1]), 64'd0);
    step();
    check("s2_wto",      64'(wto[1]), 64'd1);
    check("s2_warn_hold", 64'(warn[1]), 64'd1);
    wr_cfg(1, 0, 0, 4, 2, 0);
    check("s2_dis",      64'({wto[1], warn[1]}), 64'd0);
    wr_cfg(1, 1, 0, 4, 2, 0);
    run(10);
    kick = 4'b0010;
    step();
    check("s2_kick_warn", 64'(warn[1]), 64'd0);
    check("s2_kick_cnt",  64'(rd_cnt), 64'd0);

    // Window: legal kick at cnt=5, early kick at cnt=3.
    do_rst();
    presc = 8'd0;
    wr_cfg(2, 1, 0, 20, 0, 5);
    run(5);
    kick = 4'b0100;
    step();
    check("s3_ok_wto",  64'({wto[2], early[2]}), 64'd0);
    check("s3_ok_cnt",  64'(rd_cnt), 64'd0);
    run(3);
    kick = 4'b0100;
    step();
    check("s3_early",   64'({wto[2], early[2]}), 64'd3);

    // Lock: disable ignored, timeout still fires; reset unlocks.
    do_rst();
    wr_cfg(3, 1, 1, 7, 0, 0);
    wr_cfg(3, 0, 0, 7, 0, 0);
    run(6);
    check("s4_wto_pre", 64'(wto[3]), 64'd0);
    step();
    check("s4_wto",     64'(wto[3]), 64'd1);
    do_rst();
    wr_cfg(3, 1, 0, 7, 0, 0);
    wr_cfg(3, 0, 0, 7, 0, 0);
    run(10);
    check("s4_unlocked", 64'(wto[3]), 64'd0);

    // Kick beats same-cycle tick at cnt==tocnt; disable clears a timeout.
    do_rst();
    wr_cfg(0, 1, 0, 3, 0, 0);
    run(3);
    kick = 4'b0001;
    step();
    check("s5_kick_wto", 64'(wto[0]), 64'd0);
    check("s5_kick_cnt", 64'(rd_cnt), 64'd0);
    run(4);
    check("s5_wto",      64'(wto[0]), 64'd1);
    wr_cfg(0, 0, 0, 3, 0, 0);
    check("s5_dis",      64'(wto[0]), 64'd0);

    // Reset mid-count on all channels; prescaler restarts from zero.
    do_rst();
    presc = 8'd2;
    for (int c = 0; c < NUM_CH; c++) wr_cfg(c, 1, 0, 50, 0, 0);
    run(7);
    cfg_sel = 2'd2;
    do_rst();
    check("s6_outs",  64'({wto, warn, early, wto_any}), 64'd0);
    check("s6_cnt",   64'(rd_cnt), 64'd0);
    wr_cfg(0, 1, 0, 50, 0, 0);
    run(2);
    check("s6_pre_tick", 64'(rd_cnt), 64'd0);
    step();
    check("s6_tick",     64'(rd_cnt), 64'd1);

    // Randomized traffic against the model.
    do_rst();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if (m_on == '0 && $urandom_range(0, 7) == 0) presc = PRE_W'($urandom_range(0, 3));
      cfg_sel = CH_W'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 5) == 0) begin
        cfg_we      = 1'b1;
        cfg_en      = ($urandom_range(0, 3) != 0);
        cfg_lock    = ($urandom_range(0, 15) == 0);
        cfg_tocnt   = CNT_W'($urandom_range(0, 40));
        cfg_warncnt = CNT_W'($urandom_range(0, 40));
        cfg_winmin  = ($urandom_range(0, 1) == 0) ? '0 : CNT_W'($urandom_range(1, 8));
      end
      for (int c = 0; c < NUM_CH; c++) kick[c] = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
